// File: rtl/tdm_pkg.sv
// Shared defaults and state encoding for the TDM receive-side demultiplexer.
package tdm_pkg;

   localparam int N_SLOTS_DEF = 8;
   localparam int SLOT_W_DEF  = 3;
   localparam int ERR_W_DEF   = 8;
   localparam int ERR_MAX     = (1 << ERR_W_DEF) - 1;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_e;

endpackage

// File: rtl/tdm_demux8_slot_decoder.sv
// One-hot slot decoder with enable; selects which shadow bit captures the incoming serial bit.
module slot_decoder
   import tdm_pkg::*;
#(
   parameter int N_SLOTS = N_SLOTS_DEF,
   parameter int SLOT_W  = SLOT_W_DEF
) (
   input  logic              en_i,
   input  logic [SLOT_W-1:0] sel_i,
   output logic [N_SLOTS-1:0] onehot_o
);

   genvar gi;
   generate
      for (gi = 0; gi < N_SLOTS; gi++) begin : g_dec
         assign onehot_o[gi] = en_i && (sel_i == SLOT_W'(gi));
      end
   endgenerate

endmodule

// File: rtl/tdm_demux8.sv
// Serial-to-parallel TDM demultiplexer: slot i lands in y[i]; complete frames are published with a
// one-cycle frame_valid, and sync violations are flagged and counted (saturating).
module tdm_demux8
   import tdm_pkg::*;
#(
   parameter int N_SLOTS = N_SLOTS_DEF,
   parameter int SLOT_W  = SLOT_W_DEF,
   parameter int ERR_W   = ERR_W_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic               din,
   input  logic               sync,
   output logic [N_SLOTS-1:0] y,
   output logic               frame_valid,
   output logic               locked,
   output logic               sync_err,
   output logic [ERR_W-1:0]   err_cnt
);

   localparam logic [ERR_W-1:0]  ERR_SAT   = '1;
   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(N_SLOTS - 1);

   state_e               state_q, state_d;
   logic [SLOT_W-1:0]    cnt_q, cnt_d;
   logic [N_SLOTS-1:0]   shadow_q, shadow_d;
   logic [N_SLOTS-1:0]   y_q, y_d;
   logic                 fv_q, fv_d;
   logic                 locked_q;
   logic                 serr_q, serr_d;
   logic [ERR_W-1:0]     errcnt_q, errcnt_d;

   logic                 dec_en;
   logic [SLOT_W-1:0]    dec_sel;
   logic [N_SLOTS-1:0]   slot_we;

   // A sync bit always restarts at slot 0; otherwise only a locked, mid-frame slot is captured.
   assign dec_en  = en && (sync || (state_q == LOCKED && cnt_q != '0));
   assign dec_sel = sync ? '0 : cnt_q;

   slot_decoder #(
      .N_SLOTS (N_SLOTS),
      .SLOT_W  (SLOT_W)
   ) u_dec (
      .en_i     (dec_en),
      .sel_i    (dec_sel),
      .onehot_o (slot_we)
   );

   genvar gi;
   generate
      for (gi = 0; gi < N_SLOTS; gi++) begin : g_shadow
         assign shadow_d[gi] = slot_we[gi] ? din : shadow_q[gi];
      end
   endgenerate

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      y_d      = y_q;
      fv_d     = 1'b0;
      serr_d   = 1'b0;
      errcnt_d = errcnt_q;
      if (en) begin
         unique case (state_q)
            IDLE: begin
               if (sync) begin
                  cnt_d   = SLOT_W'(1);
                  state_d = LOCKED;
               end
            end
            LOCKED: begin
               if (cnt_q == '0 && !sync) begin
                  serr_d  = 1'b1;
                  state_d = IDLE;
                  cnt_d   = '0;
               end else if (sync) begin
                  serr_d = (cnt_q != '0);
                  cnt_d  = SLOT_W'(1);
               end else if (cnt_q == LAST_SLOT) begin
                  // shadow_d already holds the final bit, so the whole frame moves at once.
                  y_d   = shadow_d;
                  fv_d  = 1'b1;
                  cnt_d = '0;
               end else begin
                  cnt_d = cnt_q + SLOT_W'(1);
               end
            end
            default: state_d = IDLE;
         endcase
         if (serr_d && errcnt_q != ERR_SAT) begin
            errcnt_d = errcnt_q + ERR_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         shadow_q <= '0;
         y_q      <= '0;
         fv_q     <= 1'b0;
         locked_q <= 1'b0;
         serr_q   <= 1'b0;
         errcnt_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         y_q      <= y_d;
         fv_q     <= fv_d;
         locked_q <= (state_d == LOCKED);
         serr_q   <= serr_d;
         errcnt_q <= errcnt_d;
      end
   end

   assign y           = y_q;
   assign frame_valid = fv_q;
   assign locked      = locked_q;
   assign sync_err    = serr_q;
   assign err_cnt     = errcnt_q;

endmodule

// File: tb/tb_tdm_demux8.sv
// Directed bench for tdm_demux8: lock, back-to-back frames, resync, lock loss, async reset, saturation.
module tb_tdm_demux8;

   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   logic       din;
   logic       sync;
   logic [7:0] y;
   logic       frame_valid;
   logic       locked;
   logic       sync_err;
   logic [7:0] err_cnt;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int pulse_a;
   int pulse_b;

   tdm_demux8 dut (
      .clk         (clk),
      .reset       (reset),
      .en          (en),
      .din         (din),
      .sync        (sync),
      .y           (y),
      .frame_valid (frame_valid),
      .locked      (locked),
      .sync_err    (sync_err),
      .err_cnt     (err_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one edge worth of inputs, then sample 1ns after the edge.
   task automatic step(input logic e, input logic d, input logic s);
      en   = e;
      din  = d;
      sync = s;
      @(posedge clk);
      #1;
   endtask

   // Full frame with sync on slot 0; optional idle (en=0) edge after every bit.
   task automatic send_frame(input logic [7:0] data, input bit gap, input logic [7:0] prev_y,
                             input string tag);
      for (int i = 0; i < 8; i++) begin
         step(1'b1, data[i], i == 0);
         check({tag, "_fv"}, {31'd0, frame_valid}, (i == 7) ? 32'd1 : 32'd0);
         check({tag, "_y"}, {24'd0, y}, (i == 7) ? {24'd0, data} : {24'd0, prev_y});
         check({tag, "_lock"}, {31'd0, locked}, 32'd1);
         check({tag, "_serr"}, {31'd0, sync_err}, 32'd0);
         if (i == 7) pulse_b = cyc;
         if (gap) begin
            step(1'b0, 1'b0, 1'b0);
            check({tag, "_gapfv"}, {31'd0, frame_valid}, 32'd0);
         end
      end
   endtask

   initial begin
      logic [7:0] exp_err;
      reset = 1'b1;
      en    = 1'b0;
      din   = 1'b0;
      sync  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_y", {24'd0, y}, 32'd0);
      check("rst_fv", {31'd0, frame_valid}, 32'd0);
      check("rst_lock", {31'd0, locked}, 32'd0);
      check("rst_serr", {31'd0, sync_err}, 32'd0);
      check("rst_errcnt", {24'd0, err_cnt}, 32'd0);
      reset = 1'b0;
      step(1'b0, 1'b0, 1'b0);

      // Unsynced bits while IDLE are ignored silently.
      step(1'b1, 1'b1, 1'b0);
      check("idle_lock", {31'd0, locked}, 32'd0);
      check("idle_serr", {31'd0, sync_err}, 32'd0);

      send_frame(8'hA5, 1'b0, 8'h00, "fA5");
      step(1'b0, 1'b0, 1'b0);
      check("fA5_pulse1", {31'd0, frame_valid}, 32'd0);
      check("fA5_hold", {24'd0, y}, 32'hA5);

      send_frame(8'h3C, 1'b1, 8'hA5, "f3C");
      pulse_a = pulse_b;
      send_frame(8'hFF, 1'b1, 8'h3C, "fFF");
      check("pulse_spacing", pulse_b - pulse_a, 32'd16);

      // Early sync at slot 4 of a frame: resync, data 0x0F follows from that bit.
      step(1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1);
      check("early_serr", {31'd0, sync_err}, 32'd1);
      check("early_errcnt", {24'd0, err_cnt}, 32'd1);
      check("early_fv", {31'd0, frame_valid}, 32'd0);
      check("early_lock", {31'd0, locked}, 32'd1);
      check("early_y", {24'd0, y}, 32'hFF);
      for (int i = 1; i < 8; i++) begin
         step(1'b1, (i < 4), 1'b0);
         if (i == 1) check("early_serr_pulse", {31'd0, sync_err}, 32'd0);
      end
      check("resync_fv", {31'd0, frame_valid}, 32'd1);
      check("resync_y", {24'd0, y}, 32'h0F);
      check("resync_lock", {31'd0, locked}, 32'd1);

      // Missing sync on slot 0 drops lock.
      step(1'b1, 1'b1, 1'b0);
      check("miss_serr", {31'd0, sync_err}, 32'd1);
      check("miss_errcnt", {24'd0, err_cnt}, 32'd2);
      check("miss_lock", {31'd0, locked}, 32'd0);
      for (int i = 0; i < 9; i++) step(1'b1, i[0], 1'b0);
      check("unlk_serr", {31'd0, sync_err}, 32'd0);
      check("unlk_errcnt", {24'd0, err_cnt}, 32'd2);
      check("unlk_lock", {31'd0, locked}, 32'd0);
      check("unlk_y", {24'd0, y}, 32'h0F);
      check("unlk_fv", {31'd0, frame_valid}, 32'd0);

      // Async reset in the middle of slot 5 of frame 0x33.
      for (int i = 0; i < 5; i++) step(1'b1, (8'h33 >> i) & 1, i == 0);
      check("pre_rst_lock", {31'd0, locked}, 32'd1);
      #2 reset = 1'b1;
      #1;
      check("arst_y", {24'd0, y}, 32'd0);
      check("arst_lock", {31'd0, locked}, 32'd0);
      check("arst_errcnt", {24'd0, err_cnt}, 32'd0);
      check("arst_fv", {31'd0, frame_valid}, 32'd0);
      check("arst_serr", {31'd0, sync_err}, 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      send_frame(8'h81, 1'b0, 8'h00, "f81");

      // 300 missing-sync violations, relocking with a full frame between them.
      for (int k = 0; k < 300; k++) begin
         step(1'b1, 1'b0, 1'b0);
         exp_err = (k >= 254) ? 8'd255 : 8'(k + 1);
         check("sat_serr", {31'd0, sync_err}, 32'd1);
         check("sat_errcnt", {24'd0, err_cnt}, {24'd0, exp_err});
         for (int i = 0; i < 8; i++) step(1'b1, 1'b0, i == 0);
      end
      check("sat_final", {24'd0, err_cnt}, 32'd255);
      check("sat_y", {24'd0, y}, 32'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
